// File: rtl/adder_subtractor_reg.sv
// Registered two's-complement adder/subtractor with carry, overflow and zero flags.
// One shared adder: subtraction is a + ~b + 1.
module adder_subtractor_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SW  = WIDTH + 1;

  logic [WIDTH-1:0] b_x_c;
  logic [SW-1:0]    sum_c;
  logic             ovf_c;
  logic             zero_c;

  assign b_x_c  = b ^ {WIDTH{sub}};
  assign sum_c  = SW'(a) + SW'(b_x_c) + SW'(sub);
  // Same-sign operands (after inversion) producing a different-sign result.
  assign ovf_c  = (a[MSB] == b_x_c[MSB]) && (sum_c[MSB] != a[MSB]);
  assign zero_c = (sum_c[WIDTH-1:0] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result      <= '0;
      cout        <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
    end else begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) begin
        result   <= sum_c[WIDTH-1:0];
        cout     <= sum_c[WIDTH];
        overflow <= ovf_c;
        zero     <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor_reg.sv
// Directed self-checking bench for adder_subtractor_reg at WIDTH=8.
module tb_adder_subtractor_reg;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         in_valid_i = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid_o;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int errors = 0;

  adder_subtractor_reg #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .out_valid_o (out_valid_o),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .zero        (zero)
  );

  always #5 clk_i = ~clk_i;

  // Present one operation at the falling edge; return 1ns after the capturing edge.
  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    @(negedge clk_i);
    a = av; b = bv; sub = sv; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    got = {out_valid_o, result, cout, overflow, zero};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, 12'h000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_unsigned_add();
    vec_t v[4];
    logic [11:0] got, exp;
    v[0] = '{a:8'd50,  b:8'd30,  sub:1'b0, r:8'd80, c:1'b0, o:1'b0, z:1'b0};
    v[1] = '{a:8'd200, b:8'd100, sub:1'b0, r:8'd44, c:1'b1, o:1'b0, z:1'b0};
    v[2] = '{a:8'd255, b:8'd1,   sub:1'b0, r:8'd0,  c:1'b1, o:1'b0, z:1'b1};
    v[3] = '{a:8'd0,   b:8'd0,   sub:1'b0, r:8'd0,  c:1'b0, o:1'b0, z:1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].sub);
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, v[i].r, v[i].c, v[i].o, v[i].z};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL unsigned_add[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_unsigned_sub();
    vec_t v[4];
    logic [11:0] got, exp;
    v[0] = '{a:8'd100, b:8'd30,  sub:1'b1, r:8'd70,  c:1'b1, o:1'b0, z:1'b0};
    v[1] = '{a:8'd50,  b:8'd100, sub:1'b1, r:8'd206, c:1'b0, o:1'b0, z:1'b0};
    v[2] = '{a:8'd75,  b:8'd75,  sub:1'b1, r:8'd0,   c:1'b1, o:1'b0, z:1'b1};
    v[3] = '{a:8'd0,   b:8'd50,  sub:1'b1, r:8'd206, c:1'b0, o:1'b0, z:1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].sub);
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, v[i].r, v[i].c, v[i].o, v[i].z};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL unsigned_sub[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_signed_add();
    vec_t v[6];
    logic [11:0] got, exp;
    v[0] = '{a:8'd100,  b:8'd50,   sub:1'b0, r:8'h96, c:1'b0, o:1'b1, z:1'b0};
    v[1] = '{a:8'd127,  b:8'd1,    sub:1'b0, r:8'h80, c:1'b0, o:1'b1, z:1'b0};
    v[2] = '{a:8'h9C,   b:8'hCE,   sub:1'b0, r:8'd106, c:1'b1, o:1'b1, z:1'b0};
    v[3] = '{a:8'h80,   b:8'hFF,   sub:1'b0, r:8'd127, c:1'b1, o:1'b1, z:1'b0};
    v[4] = '{a:8'd50,   b:8'hCE,   sub:1'b0, r:8'd0,   c:1'b1, o:1'b0, z:1'b1};
    v[5] = '{a:8'd100,  b:8'hCE,   sub:1'b0, r:8'd50,  c:1'b1, o:1'b0, z:1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].sub);
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, v[i].r, v[i].c, v[i].o, v[i].z};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL signed_add[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_signed_sub();
    vec_t v[4];
    logic [11:0] got, exp;
    v[0] = '{a:8'd100, b:8'hCE, sub:1'b1, r:8'h96,  c:1'b0, o:1'b1, z:1'b0};
    v[1] = '{a:8'd127, b:8'hFF, sub:1'b1, r:8'h80,  c:1'b0, o:1'b1, z:1'b0};
    v[2] = '{a:8'h80,  b:8'd1,  sub:1'b1, r:8'd127, c:1'b1, o:1'b1, z:1'b0};
    v[3] = '{a:8'hCE,  b:8'hE2, sub:1'b1, r:8'hEC,  c:1'b0, o:1'b0, z:1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].sub);
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, v[i].r, v[i].c, v[i].o, v[i].z};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL signed_sub[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_edge_patterns();
    vec_t v[4];
    logic [11:0] got, exp;
    v[0] = '{a:8'hFF, b:8'hFF, sub:1'b0, r:8'hFE, c:1'b1, o:1'b0, z:1'b0};
    v[1] = '{a:8'hAA, b:8'h55, sub:1'b0, r:8'hFF, c:1'b0, o:1'b0, z:1'b0};
    v[2] = '{a:8'h7F, b:8'h7F, sub:1'b0, r:8'hFE, c:1'b0, o:1'b1, z:1'b0};
    v[3] = '{a:8'h80, b:8'h80, sub:1'b0, r:8'h00, c:1'b1, o:1'b1, z:1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].sub);
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, v[i].r, v[i].c, v[i].o, v[i].z};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL edge_pattern[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  // Same operands every cycle, sub toggling: each result must follow its own edge's sub.
  task automatic test_back_to_back();
    logic [W-1:0] exp_r[3];
    logic [11:0]  got, exp;
    exp_r[0] = 8'd13; exp_r[1] = 8'd7; exp_r[2] = 8'd13;
    for (int i = 0; i < 3; i++) begin
      drive(8'd10, 8'd3, (i == 1));
      got = {out_valid_o, result, cout, overflow, zero};
      exp = {1'b1, exp_r[i], (i == 1), 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got v/r/c/o/z=%h expected %h", i, got, exp);
      end
    end
    idle();
  endtask

  task automatic test_hold();
    logic [11:0] got;
    drive(8'hFF, 8'h01, 1'b0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    a = 8'h12; b = 8'h34; sub = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    got = {out_valid_o, result, cout, overflow, zero};
    checks++;
    if (got !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hold_idle: got v/r/c/o/z=%h expected %h", got, {1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [11:0] got;
    drive(8'h80, 8'h80, 1'b0);
    drive(8'h7F, 8'h7F, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    got = {out_valid_o, result, cout, overflow, zero};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got v/r/c/o/z=%h expected %h", got, 12'h000);
    end
    @(posedge clk_i);
    #1;
    got = {out_valid_o, result, cout, overflow, zero};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_held_edge: got v/r/c/o/z=%h expected %h", got, 12'h000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(8'd50, 8'd30, 1'b0);
    got = {out_valid_o, result, cout, overflow, zero};
    checks++;
    if (got !== {1'b1, 8'd80, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_capture: got v/r/c/o/z=%h expected %h", got, {1'b1, 8'd80, 1'b0, 1'b0, 1'b0});
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_unsigned_add();
    test_unsigned_sub();
    test_signed_add();
    test_signed_sub();
    test_edge_patterns();
    test_back_to_back();
    test_hold();
    test_reset_mid_stream();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
